// File: rtl/word_to_halfword_serializer.sv
// Splits 32-bit words into two 16-bit beats with valid/ready on both sides.
// Optional WORD_TO_HALFWORD_ZERO_COMPRESS_EN sends a zero-upper word as a single beat.
module word_to_halfword_serializer #(
  parameter int unsigned LOW_FIRST = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      InData,
  input  logic             InValid,
  output logic             InReady,
  output logic [15:0]      OutData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             OutLast,
  output logic [CNT_W-1:0] WordCount
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic [15:0]      data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             single;
  logic             in_single;
  logic             out_last;
  logic             out_valid;
  logic             accept;
  logic             beat;
  logic [15:0]      in_first;
  logic [15:0]      hold_second;

`ifdef WORD_TO_HALFWORD_ZERO_COMPRESS_EN
  logic single_q, single_d;

  assign in_single = (InData[31:16] == 16'h0000);
  assign single    = single_q;
  // A single-beat word always presents its low half, whatever the beat order.
  assign in_first  = (in_single || (LOW_FIRST != 0)) ? InData[15:0] : InData[31:16];
`else
  assign in_single = 1'b0;
  assign single    = 1'b0;
  assign in_first  = (LOW_FIRST != 0) ? InData[15:0] : InData[31:16];
`endif

  assign hold_second = (LOW_FIRST != 0) ? hold_q[31:16] : hold_q[15:0];

  assign out_valid = (state_q == BEAT0) || (state_q == BEAT1);
  assign out_last  = (state_q == BEAT1) || ((state_q == BEAT0) && single);

  // A new word may enter in the same cycle the final beat of the old one drains.
  assign InReady = (state_q == EMPTY) || (out_last && OutReady);
  assign accept  = InValid && InReady;
  assign beat    = out_valid && OutReady;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    data_d   = data_q;
    count_d  = count_q;
`ifdef WORD_TO_HALFWORD_ZERO_COMPRESS_EN
    single_d = single_q;
`endif

    if (beat && out_last) begin
      count_d = count_q + 1'b1;
    end

    if (beat && !out_last) begin
      state_d = BEAT1;
      data_d  = hold_second;
    end else if (beat) begin
      state_d = EMPTY;
    end

    // Accept can only happen when empty or when the last beat completes, so it wins.
    if (accept) begin
      state_d  = BEAT0;
      hold_d   = InData;
      data_d   = in_first;
`ifdef WORD_TO_HALFWORD_ZERO_COMPRESS_EN
      single_d = in_single;
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= EMPTY;
      hold_q   <= 32'h0;
      data_q   <= 16'h0;
      count_q  <= '0;
`ifdef WORD_TO_HALFWORD_ZERO_COMPRESS_EN
      single_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      data_q   <= data_d;
      count_q  <= count_d;
`ifdef WORD_TO_HALFWORD_ZERO_COMPRESS_EN
      single_q <= single_d;
`endif
    end
  end

  assign OutData   = data_q;
  assign OutValid  = out_valid;
  assign OutLast   = out_last;
  assign WordCount = count_q;

  // in_single is only consumed by the compress build.
  logic unused_in_single;
  assign unused_in_single = in_single;

endmodule

// File: doc/word_to_halfword_serializer.md
Name: word_to_halfword_serializer

Overview:
- Converts 32-bit datapath words into a stream of 16-bit halfwords. It is the narrowing counterpart of the 16-to-32 zero-extension path.
- Sits between a 32-bit producer (register file or memory read port) and a 16-bit bus or peripheral.
- Valid/ready handshake on both sides; one-word holding register; back-to-back words at full halfword rate.
- Optionally drops a redundant zero upper half, recovering the original 16-bit value.

Parameters:
- LOW_FIRST, 1, 1 = bits [15:0] sent first then [31:16]; 0 = [31:16] first then [15:0]
- CNT_W, 16, width of the completed-word counter

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- InData  input  32  word to serialize
- InValid  input  1  InData valid
- InReady  output  1  block accepts InData this cycle
- OutData  output  16  current halfword
- OutValid  output  1  OutData valid
- OutReady  input  1  consumer accepts OutData this cycle
- OutLast  output  1  current halfword is the final beat of its word
- WordCount  output  CNT_W  number of words fully emitted, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock, Clk; reset is asynchronous and active-high, Reset.
- Reset values (immediate on Reset assertion, independent of Clk):
  - state = EMPTY, holding register = 0, OutValid = 0, OutLast = 0, OutData = 0, WordCount = 0, InReady = 1.
- Reset asserted mid-word: the partially sent word is discarded; no further beats of it appear after reset release.
- States:
  - EMPTY: nothing held.
  - BEAT0: first halfword presented.
  - BEAT1: second halfword presented.
- Input handshake: a word is accepted on a rising edge when InValid and InReady are both 1.
- InReady is combinational:
  - 1 in EMPTY.
  - 1 when the current beat is the last beat of its word and OutReady = 1, so a new word is accepted in the same cycle the old word completes.
  - 0 otherwise.
- Output handshake: a beat completes on a rising edge when OutValid and OutReady are both 1.
- OutValid = 1 in BEAT0 and BEAT1; OutValid is never dependent on OutReady.
- OutData and OutValid are registered state outputs; OutData is held stable while OutValid = 1 and OutReady = 0.
- Transitions:
  - EMPTY --accept--> BEAT0.
  - BEAT0 --beat, word has two beats--> BEAT1.
  - BEAT0 --beat, word has one beat--> BEAT0 if a new word is accepted that edge, else EMPTY.
  - BEAT1 --beat--> BEAT0 if a new word is accepted that edge, else EMPTY.
  - Any state with no beat completing: hold.
- Halfword selection:
  - BEAT0 presents the first half per LOW_FIRST; BEAT1 presents the other half.
  - Sequence for 0xAAAABBBB: LOW_FIRST=1 gives 0xBBBB then 0xAAAA; LOW_FIRST=0 gives 0xAAAA then 0xBBBB.
- OutLast = 1 in BEAT1, and in BEAT0 only when the held word has a single beat (see Optional Feature).
- WordCount increments by 1 on each completed beat with OutLast = 1; it wraps from 2^CNT_W-1 to 0.
- Latency: word accepted at edge N produces its first beat visible after edge N. Minimum 2 cycles per two-beat word, with no idle cycle between consecutive words.
- InValid while InReady = 0 is allowed; the producer holds the word, and the block neither samples nor loses it.

Optional Feature:
- Macro: WORD_TO_HALFWORD_ZERO_COMPRESS_EN.
- Defined:
  - On accept, if InData[31:16] == 0, the word is flagged single-beat.
  - Only the BEAT0 beat is sent: OutData = InData[15:0] regardless of LOW_FIRST, with OutLast = 1.
  - WordCount increments on that beat.
  - This exactly inverts the zero-extension path.
- Not defined: every word is always two beats; no zero detection logic is present.

Test Plan:
- Reset, then InData=0x12345678, InValid=1, OutReady=1, LOW_FIRST=1 -> beats 0x5678 (OutLast=0) then 0x1234 (OutLast=1); WordCount=1.
- Same word with LOW_FIRST=0 -> beats 0x1234 then 0x5678; OutLast only on 0x5678.
- Three words 0x00010002, 0x00030004, 0x00050006 offered continuously, OutReady=1 -> six beats on six consecutive edges with no OutValid gap; WordCount=3.
- OutReady=0 for 4 cycles during BEAT0 of 0xDEADBEEF -> OutData stays 0xBEEF, InReady=0, next InValid word not taken; after release, 0xDEAD then the next word follow.
- Reset asserted during BEAT1 of 0xCAFEF00D -> OutValid=0 and WordCount=0 immediately; after release no 0xCAFE beat appears.
- Macro defined, InData=0x0000ABCD then 0x0001ABCD -> single beat 0xABCD (OutLast=1), then two beats 0xABCD and 0x0001; WordCount=2. Macro undefined, 0x0000ABCD -> two beats 0xABCD then 0x0000.
